datapath_pipe: RTL and testbench

//   Parametrised two-stage datapath: register file, operand/constant muxing, ALU/shifter and an iterative multiplier.

---
 rtl/datapath_pipe.sv | 171 +++++++++++++++++
 tb/tb_datapath_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// Two-stage datapath: register file, operand/constant muxing, ALU/shifter and
// an iterative shift-add multiplier, with WB->EX forwarding and registered flags.
module datapath_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  output logic                     in_ready,
  input  logic [3:0]               op_sel,
  input  logic [$clog2(NREGS)-1:0] A_sel,
  input  logic [$clog2(NREGS)-1:0] B_sel,
  input  logic [$clog2(NREGS)-1:0] dest_sel,
  input  logic                     load_en,
  input  logic                     const_sel,
  input  logic [WIDTH-1:0]         const_in,
  input  logic                     data_sel,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         A_out,
  output logic [WIDTH-1:0]         B_out,
  output logic [WIDTH-1:0]         Br,
  output logic                     V,
  output logic                     C,
  output logic                     N,
  output logic                     Z,
  output logic                     busy,
  output logic                     wb_valid
);

  localparam int unsigned SEL_W = $clog2(NREGS);
  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_ASR = 4'd8;
  localparam logic [3:0] OP_PSB = 4'd9;
  localparam logic [3:0] OP_INC = 4'd10;
  localparam logic [3:0] OP_DEC = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;

  logic [WIDTH-1:0] rf [NREGS];
  logic [SEL_W-1:0] wb_dest;
  logic [WIDTH-1:0] wb_data;

  logic [WIDTH-1:0] mul_hi, mul_lo, mul_mcand;
  logic [CNT_W-1:0] mul_cnt;
  logic [SEL_W-1:0] mul_dest;
  logic             mul_load;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

  logic [SH_W-1:0]    sh;
  logic [WIDTH-1:0]   alu_b, f;
  logic [WIDTH:0]     sum, shl, shr;
  logic signed [WIDTH:0] asr;
  logic               fc, fv;

  assign in_ready = ~busy;

  // Distance-1 forwarding from the WB register.
  assign A_out = (wb_valid && wb_dest == A_sel) ? wb_data : rf[A_sel];
  assign B_out = (wb_valid && wb_dest == B_sel) ? wb_data : rf[B_sel];
  assign Br    = const_sel ? const_in : B_out;
  assign sh    = Br[SH_W-1:0];

  // One shift-add step: low half holds remaining multiplier bits.
  assign mul_sum   = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mul_mcand} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mul_lo[WIDTH-1:1]};

  // ALU / shifter; shifts carry one extra bit to capture the last bit shifted out.
  always_comb begin
    alu_b = Br;
    if (op_sel == OP_INC || op_sel == OP_DEC) alu_b = ONE;
    if (op_sel == OP_SUB || op_sel == OP_DEC) sum = {1'b0, A_out} - {1'b0, alu_b};
    else                                      sum = {1'b0, A_out} + {1'b0, alu_b};
    shl = {1'b0, A_out} << sh;
    shr = {A_out, 1'b0} >> sh;
    asr = $signed({A_out, 1'b0}) >>> sh;
    f  = A_out;
    fc = 1'b0;
    fv = 1'b0;
    case (op_sel)
      OP_ADD, OP_INC: begin
        f  = sum[WIDTH-1:0];
        fc = sum[WIDTH];
        fv = (A_out[WIDTH-1] == alu_b[WIDTH-1]) && (sum[WIDTH-1] != A_out[WIDTH-1]);
      end
      OP_SUB, OP_DEC: begin
        f  = sum[WIDTH-1:0];
        fc = sum[WIDTH];
        fv = (A_out[WIDTH-1] != alu_b[WIDTH-1]) && (sum[WIDTH-1] != A_out[WIDTH-1]);
      end
      OP_AND: f = A_out & Br;
      OP_OR:  f = A_out | Br;
      OP_XOR: f = A_out ^ Br;
      OP_NOT: f = ~A_out;
      OP_SHL: begin f = shl[WIDTH-1:0]; fc = shl[WIDTH]; end
      OP_SHR: begin f = shr[WIDTH:1];   fc = shr[0];     end
      OP_ASR: begin f = asr[WIDTH:1];   fc = asr[0];     end
      OP_PSB: f = Br;
      default: f = A_out;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
      wb_valid  <= 1'b0;
      wb_dest   <= '0;
      wb_data   <= '0;
      {V, C, N, Z} <= 4'b0;
      busy      <= 1'b0;
      mul_cnt   <= '0;
      mul_hi    <= '0;
      mul_lo    <= '0;
      mul_mcand <= '0;
      mul_dest  <= '0;
      mul_load  <= 1'b0;
    end else begin
      if (wb_valid) rf[wb_dest] <= wb_data;
      wb_valid <= 1'b0;
      if (busy) begin
        mul_hi <= mul_hi_nx;
        mul_lo <= mul_lo_nx;
        if (mul_cnt == CNT_W'(WIDTH - 1)) begin
          busy     <= 1'b0;
          wb_valid <= mul_load;
          wb_dest  <= mul_dest;
          wb_data  <= mul_lo_nx;
          N <= mul_lo_nx[WIDTH-1];
          Z <= (mul_lo_nx == '0);
          C <= (mul_hi_nx != '0);
          V <= 1'b0;
        end else begin
          mul_cnt <= mul_cnt + CNT_W'(1);
        end
      end else if (issue) begin
        if (op_sel == OP_MUL && !data_sel) begin
          busy      <= 1'b1;
          mul_cnt   <= '0;
          mul_hi    <= '0;
          mul_lo    <= Br;
          mul_mcand <= A_out;
          mul_dest  <= dest_sel;
          mul_load  <= load_en;
        end else begin
          wb_valid <= load_en;
          wb_dest  <= dest_sel;
          wb_data  <= data_sel ? data_in : f;
          if (op_sel != OP_MUL) begin
            N <= f[WIDTH-1];
            Z <= (f == '0);
            C <= fc;
            V <= fv;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Self-checking bench for datapath_pipe: directed scenarios plus random
// instruction streams against an arithmetic reference model.
module tb_datapath_pipe;

  logic        clk, rst_n, issue, load_en, const_sel, data_sel;
  logic [3:0]  op_sel, a_sel, b_sel, dest_sel;
  logic [15:0] const_in, data_in, a_out, b_out, br;
  logic        v, c, n, z, busy, in_ready, wb_valid;

  logic        w8_issue, w8_ld, w8_cs, w8_ds;
  logic [3:0]  w8_op;
  logic [1:0]  w8_a, w8_b, w8_d;
  logic [7:0]  w8_ci, w8_di, w8_aout, w8_bout, w8_br;
  logic        w8_v, w8_c, w8_n, w8_z, w8_busy, w8_rdy, w8_wbv;

  int tests = 0;
  int fails = 0;

  datapath_pipe #(.WIDTH(16), .NREGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue), .in_ready(in_ready), .op_sel(op_sel),
    .A_sel(a_sel), .B_sel(b_sel), .dest_sel(dest_sel), .load_en(load_en),
    .const_sel(const_sel), .const_in(const_in), .data_sel(data_sel), .data_in(data_in),
    .A_out(a_out), .B_out(b_out), .Br(br), .V(v), .C(c), .N(n), .Z(z),
    .busy(busy), .wb_valid(wb_valid)
  );

  datapath_pipe #(.WIDTH(8), .NREGS(4)) u8 (
    .clk(clk), .rst_n(rst_n), .issue(w8_issue), .in_ready(w8_rdy), .op_sel(w8_op),
    .A_sel(w8_a), .B_sel(w8_b), .dest_sel(w8_d), .load_en(w8_ld),
    .const_sel(w8_cs), .const_in(w8_ci), .data_sel(w8_ds), .data_in(w8_di),
    .A_out(w8_aout), .B_out(w8_bout), .Br(w8_br), .V(w8_v), .C(w8_c), .N(w8_n), .Z(w8_z),
    .busy(w8_busy), .wb_valid(w8_wbv)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [15:0] m_rf [16];
  logic        m_wbv, m_v, m_c, m_n, m_z, m_busy, m_mhi_nz, m_mld;
  logic [3:0]  m_wbd, m_mdest;
  logic [15:0] m_wbdata, m_mlo;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] s);
    return (m_wbv && m_wbd == s) ? m_wbdata : m_rf[s];
  endfunction

  task automatic alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] f, output logic fc, output logic fv);
    int ua, ub, sa, sb, r, sr, sh;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    sh = int'(b[3:0]);
    fc = 1'b0; fv = 1'b0;
    case (op)
      4'd0:  begin r = ua + ub; sr = sa + sb; fc = r > 32'hFFFF; end
      4'd1:  begin r = ua - ub; sr = sa - sb; fc = ua < ub; end
      4'd10: begin r = ua + 1;  sr = sa + 1;  fc = r > 32'hFFFF; end
      4'd11: begin r = ua - 1;  sr = sa - 1;  fc = ua < 1; end
      4'd2:  r = ua & ub;
      4'd3:  r = ua | ub;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ~ua;
      4'd6:  begin r = ua << sh; if (sh > 0) fc = ((ua >> (16 - sh)) & 1) != 0; end
      4'd7:  begin r = ua >> sh; if (sh > 0) fc = ((ua >> (sh - 1)) & 1) != 0; end
      4'd8:  begin r = sa >>> sh; if (sh > 0) fc = ((ua >> (sh - 1)) & 1) != 0; end
      4'd9:  r = ub;
      default: r = ua;
    endcase
    if (op inside {4'd0, 4'd1, 4'd10, 4'd11}) fv = (sr > 32767) || (sr < -32768);
    f = 16'(r & 32'hFFFF);
  endtask

  task automatic model_edge();
    logic [15:0] a, b, f;
    logic fc, fv;
    longint prod;
    a = fwd(a_sel);
    b = const_sel ? const_in : fwd(b_sel);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_wbv = 0; m_wbd = '0; m_wbdata = '0;
      {m_v, m_c, m_n, m_z} = 4'b0;
      m_busy = 0; m_left = 0;
    end else begin
      if (m_wbv) m_rf[m_wbd] = m_wbdata;
      m_wbv = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_wbv = m_mld; m_wbd = m_mdest; m_wbdata = m_mlo;
          m_n = m_mlo[15]; m_z = (m_mlo == 0); m_c = m_mhi_nz; m_v = 0;
        end
      end else if (issue) begin
        if (op_sel == 4'd12 && !data_sel) begin
          prod = longint'(a) * longint'(b);
          m_mlo = 16'(prod & 64'hFFFF);
          m_mhi_nz = (prod >> 16) != 0;
          m_busy = 1; m_left = 16;
          m_mdest = dest_sel; m_mld = load_en;
        end else begin
          alu(op_sel, a, b, f, fc, fv);
          m_wbv = load_en; m_wbd = dest_sel;
          m_wbdata = data_sel ? data_in : f;
          if (op_sel != 4'd12) begin
            m_n = f[15]; m_z = (f == 0); m_c = fc; m_v = fv;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("A_out", 32'(a_out), 32'(fwd(a_sel)));
    chk("B_out", 32'(b_out), 32'(fwd(b_sel)));
    chk("Br", 32'(br), 32'(const_sel ? const_in : fwd(b_sel)));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    chk("wb_valid", 32'(wb_valid), 32'(m_wbv));
    chk("flags", 32'({v, c, n, z}), 32'({m_v, m_c, m_n, m_z}));
  endtask

  // Inputs are set after a falling edge; check, clock, update model.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic ins(input logic iss, input logic [3:0] op, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] d, input logic ld,
                     input logic cs, input logic [15:0] ci, input logic ds, input logic [15:0] di);
    issue = iss; op_sel = op; a_sel = a; b_sel = b; dest_sel = d; load_en = ld;
    const_sel = cs; const_in = ci; data_sel = ds; data_in = di;
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    ins(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    {w8_issue, w8_ld, w8_cs, w8_ds} = 4'b0;
    w8_op = 4'd0; w8_a = 2'd0; w8_b = 2'd0; w8_d = 2'd0; w8_ci = 8'h0; w8_di = 8'h0;
    m_busy = 0; m_left = 0; m_wbv = 0;
    @(negedge clk);
    model_edge();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ins(0, 4'd0, 4'(i), 4'(15 - i), 4'd0, 0, 0, 16'h0, 0, 16'h0);
      #1 chk("reset_reg", 32'(a_out), 32'h0);
      step();
    end

    // R1 = 0x7FFF, R2 = R1 + 1
    ins(1, 4'd9, 4'd0, 4'd0, 4'd1, 1, 0, 16'h0, 1, 16'h7FFF); step();
    ins(1, 4'd0, 4'd1, 4'd0, 4'd2, 1, 1, 16'h0001, 0, 16'h0); step();
    ins(0, 4'd0, 4'd2, 4'd0, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    #1 chk("add_ovf_res", 32'(a_out), 32'h8000);
    chk("add_ovf_flags", 32'({v, c, n, z}), 32'b1010);
    step();

    // Back-to-back forwarding
    ins(1, 4'd0, 4'd1, 4'd1, 4'd3, 1, 0, 16'h0, 0, 16'h0); step();
    ins(1, 4'd4, 4'd3, 4'd3, 4'd4, 1, 0, 16'h0, 0, 16'h0);
    #1 chk("fwd_a", 32'(a_out), 32'hFFFE);
    step();
    ins(0, 4'd0, 4'd4, 4'd3, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    #1 chk("xor_res", 32'(a_out), 32'h0);
    chk("xor_z", 32'(z), 32'h1);
    step();

    // SUB borrow, SHL carry
    ins(1, 4'd9, 4'd0, 4'd0, 4'd5, 1, 0, 16'h0, 1, 16'h0003); step();
    ins(1, 4'd9, 4'd0, 4'd0, 4'd6, 1, 0, 16'h0, 1, 16'h0005); step();
    ins(1, 4'd1, 4'd5, 4'd6, 4'd7, 1, 0, 16'h0, 0, 16'h0); step();
    ins(1, 4'd9, 4'd7, 4'd0, 4'd8, 1, 0, 16'h0, 1, 16'h8001);
    #1 chk("sub_res", 32'(a_out), 32'hFFFE);
    chk("sub_flags", 32'({v, c, n, z}), 32'b0110);
    step();
    ins(1, 4'd6, 4'd8, 4'd0, 4'd9, 1, 1, 16'h0001, 0, 16'h0); step();
    ins(0, 4'd0, 4'd9, 4'd0, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    #1 chk("shl_res", 32'(a_out), 32'h0002);
    chk("shl_c", 32'(c), 32'h1);
    step();

    // MUL 0x0100 * 0x0101, junk issues during busy
    ins(1, 4'd9, 4'd0, 4'd0, 4'd10, 1, 0, 16'h0, 1, 16'h0100); step();
    ins(1, 4'd9, 4'd0, 4'd0, 4'd11, 1, 0, 16'h0, 1, 16'h0101); step();
    ins(1, 4'd12, 4'd10, 4'd11, 4'd12, 1, 0, 16'h0, 0, 16'h0); step();
    for (int i = 0; i < 16; i++) begin
      ins(1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1,
          1'($urandom), pick16(), 1'($urandom), pick16());
      #1 chk("mul_busy", 32'({busy, in_ready}), 32'b10);
      step();
    end
    ins(0, 4'd0, 4'd12, 4'd0, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    #1 chk("mul_done", 32'({busy, in_ready, wb_valid}), 32'b011);
    chk("mul_res", 32'(a_out), 32'h0100);
    chk("mul_flags", 32'({v, c, n, z}), 32'b0100);
    step();

    // Reset in busy cycle 5 aborts the multiply
    ins(1, 4'd12, 4'd1, 4'd1, 4'd13, 1, 0, 16'h0, 0, 16'h0); step();
    ins(0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 16'h0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    #1 chk("rst_state", 32'({busy, wb_valid, v, c, n, z}), 32'h0);
    for (int i = 0; i < 20; i++) begin
      ins(0, 4'd0, 4'(i), 4'(i + 1), 4'd0, 0, 0, 16'h0, 0, 16'h0);
      #1 chk("rst_reg", 32'({a_out, wb_valid}), 32'h0);
      step();
    end

    // Random instruction stream
    for (int i = 0; i < 600; i++) begin
      ins(($urandom_range(0, 9) < 8), 4'($urandom), 4'($urandom), 4'($urandom),
          4'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom), pick16(),
          ($urandom_range(0, 4) == 0), pick16());
      step();
    end
    for (int i = 0; i < 20; i++) begin
      ins(0, 4'd0, 4'(i), 4'(i + 7), 4'd0, 0, 0, 16'h0, 0, 16'h0);
      step();
    end

    // 8-bit, 4-register instance
    chk("w8_reset", 32'({w8_aout, w8_busy, w8_wbv, w8_v, w8_c, w8_n, w8_z}), 32'h0);
    w8_issue = 1; w8_op = 4'd9; w8_d = 2'd1; w8_ld = 1; w8_ds = 1; w8_di = 8'hFF;
    step();
    w8_op = 4'd0; w8_a = 2'd1; w8_d = 2'd2; w8_ds = 0; w8_cs = 1; w8_ci = 8'h01;
    step();
    w8_issue = 0; w8_a = 2'd2; w8_cs = 0; w8_b = 2'd1;
    #1 chk("w8_add_res", 32'(w8_aout), 32'h00);
    chk("w8_add_flags", 32'({w8_v, w8_c, w8_n, w8_z}), 32'b0101);
    chk("w8_b", 32'(w8_bout), 32'hFF);
    step();
    step();
    #1 chk("w8_regfile", 32'({w8_aout, w8_bout, w8_wbv}), 32'({8'h00, 8'hFF, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
